// File: rtl/one_to_four_dist_if.sv
// Handshake bundle between a producer/consumer group and the 1-to-4 distributor.
// The distributor takes the slave view; the environment driving it takes master.
interface one_to_four_dist_if #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CNT_W = 8
);
  logic [WIDTH-1:0] in_data;
  logic [1:0]       in_sel;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] q0;
  logic [WIDTH-1:0] q1;
  logic [WIDTH-1:0] q2;
  logic [WIDTH-1:0] q3;
  logic [3:0]       out_valid;
  logic [3:0]       out_ready;
  logic [CNT_W-1:0] dcount0;
  logic [CNT_W-1:0] dcount1;
  logic [CNT_W-1:0] dcount2;
  logic [CNT_W-1:0] dcount3;

  modport master (
    output in_data, in_sel, in_valid, out_ready,
    input  in_ready, q0, q1, q2, q3, out_valid, dcount0, dcount1, dcount2, dcount3
  );

  modport slave (
    input  in_data, in_sel, in_valid, out_ready,
    output in_ready, q0, q1, q2, q3, out_valid, dcount0, dcount1, dcount2, dcount3
  );
endinterface

// File: rtl/one_to_four_dist.sv
// Registered 1-to-4 distributor: one input word steered by in_sel into one of four
// single-entry holding slots, each drained by its own valid/ready consumer.
module one_to_four_dist #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CNT_W = 8
) (
  input logic               clk,
  input logic               reset,
  one_to_four_dist_if.slave bus
);

  typedef enum logic {StEmpty, StFull} slot_state_e;

  slot_state_e      st_q  [4];
  logic [WIDTH-1:0] q_q   [4];
  logic [CNT_W-1:0] cnt_q [4];
  logic [3:0]       vld;
  logic             acc;

  always_comb begin
    vld = '0;
    for (int i = 0; i < 4; i++) begin
      vld[i] = (st_q[i] == StFull);
    end
  end

  // Only the selected slot can stall the producer; no path from in_valid.
  assign bus.in_ready = ~vld[bus.in_sel] | bus.out_ready[bus.in_sel];
  assign acc          = bus.in_valid & bus.in_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) begin
        st_q[i]  <= StEmpty;
        q_q[i]   <= '0;
        cnt_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        // A load wins over a consume so a full slot refills without a bubble.
        if (acc && (bus.in_sel == 2'(i))) begin
          q_q[i]  <= bus.in_data;
          st_q[i] <= StFull;
        end else if (vld[i] && bus.out_ready[i]) begin
          st_q[i] <= StEmpty;
        end
        if (vld[i] && bus.out_ready[i]) begin
          cnt_q[i] <= cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  assign bus.out_valid = vld;
  assign bus.q0        = q_q[0];
  assign bus.q1        = q_q[1];
  assign bus.q2        = q_q[2];
  assign bus.q3        = q_q[3];
  assign bus.dcount0   = cnt_q[0];
  assign bus.dcount1   = cnt_q[1];
  assign bus.dcount2   = cnt_q[2];
  assign bus.dcount3   = cnt_q[3];

endmodule

// File: tb/tb_one_to_four_dist.sv
// Directed bench for one_to_four_dist: per-slot scoreboard queues fed on accept and
// drained on consume, plus a reference model of slot occupancy and counters.
module tb_one_to_four_dist;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  one_to_four_dist_if #(.WIDTH(16), .CNT_W(8)) bus ();

  one_to_four_dist #(.WIDTH(16), .CNT_W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [3:0]  mv;
  logic [15:0] mq   [4];
  logic [7:0]  mcnt [4];
  logic [15:0] sbq  [4][$];

  function automatic logic [15:0] get_q(input int i);
    case (i)
      0:       return bus.q0;
      1:       return bus.q1;
      2:       return bus.q2;
      default: return bus.q3;
    endcase
  endfunction

  function automatic logic [7:0] get_cnt(input int i);
    case (i)
      0:       return bus.dcount0;
      1:       return bus.dcount1;
      2:       return bus.dcount2;
      default: return bus.dcount3;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    mv = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      mq[i]   = 16'h0;
      mcnt[i] = 8'h0;
      sbq[i].delete();
    end
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, "_out_valid"}, {28'h0, bus.out_valid}, {28'h0, mv});
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("%s_q%0d", tag, i), {16'h0, get_q(i)}, {16'h0, mq[i]});
      chk($sformatf("%s_dcount%0d", tag, i), {24'h0, get_cnt(i)}, {24'h0, mcnt[i]});
    end
  endtask

  // One clock cycle: drive at negedge, check in_ready and delivered words before the
  // edge, update the model at the edge, then check the registered outputs.
  task automatic cyc(input logic v, input logic [1:0] s, input logic [15:0] d,
                     input logic [3:0] r);
    logic       exp_rdy;
    logic       exp_acc;
    logic [3:0] con;
    @(negedge clk);
    bus.in_valid  = v;
    bus.in_sel    = s;
    bus.in_data   = d;
    bus.out_ready = r;
    #1;
    exp_rdy = ~mv[s] | r[s];
    exp_acc = v & exp_rdy;
    chk("in_ready", {31'h0, bus.in_ready}, {31'h0, exp_rdy});
    con = mv & r;
    for (int i = 0; i < 4; i++) begin
      if (con[i]) begin
        if (sbq[i].size() > 0) begin
          chk($sformatf("deliver_q%0d", i), {16'h0, get_q(i)}, {16'h0, sbq[i].pop_front()});
        end else begin
          chk($sformatf("deliver_q%0d_nothing_pending", i), 32'h1, 32'h0);
        end
        mcnt[i] = mcnt[i] + 8'h1;
      end
    end
    for (int i = 0; i < 4; i++) begin
      if (exp_acc && (s == 2'(i))) begin
        mv[i] = 1'b1;
        mq[i] = d;
        sbq[i].push_back(d);
      end else if (con[i]) begin
        mv[i] = 1'b0;
      end
    end
    @(posedge clk);
    #1;
    check_outputs("cyc");
  endtask

  initial begin
    checks        = 0;
    failures      = 0;
    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_sel    = 2'b00;
    bus.in_data   = 16'h0;
    bus.out_ready = 4'b0000;
    model_reset();

    // Reset state
    #12;
    check_outputs("reset");
    chk("reset_in_ready", {31'h0, bus.in_ready}, 32'h1);
    @(negedge clk);
    reset = 1'b0;

    // Single transfer to slot 1, no consumers ready
    cyc(1'b1, 2'b01, 16'h3A5C, 4'b0000);
    chk("single_q1", {16'h0, bus.q1}, 32'h3A5C);
    chk("single_out_valid", {28'h0, bus.out_valid}, 32'h2);
    cyc(1'b0, 2'b01, 16'h0, 4'b0000);
    chk("single_stall_sel1", {31'h0, bus.in_ready}, 32'h0);
    cyc(1'b0, 2'b00, 16'h0, 4'b0000);
    chk("single_free_sel0", {31'h0, bus.in_ready}, 32'h1);
    cyc(1'b0, 2'b00, 16'h0, 4'b0010);

    // Back-to-back streaming into slot 3
    for (int k = 1; k <= 8; k++) begin
      cyc(1'b1, 2'b11, 16'(k), 4'b1000);
      chk("stream_q3", {16'h0, bus.q3}, k);
      chk("stream_valid3", {31'h0, bus.out_valid[3]}, 32'h1);
    end
    cyc(1'b0, 2'b00, 16'h0, 4'b1000);
    chk("stream_dcount3", {24'h0, bus.dcount3}, 32'h8);

    // Simultaneous consume and reload on slot 0
    cyc(1'b1, 2'b00, 16'hAAAA, 4'b0000);
    cyc(1'b1, 2'b00, 16'hBBBB, 4'b0001);
    chk("simul_q0", {16'h0, bus.q0}, 32'hBBBB);
    chk("simul_valid0", {31'h0, bus.out_valid[0]}, 32'h1);
    chk("simul_dcount0", {24'h0, bus.dcount0}, 32'h1);
    cyc(1'b0, 2'b00, 16'h0, 4'b0001);

    // Isolation: slot 2 stalled must not block slots 0 and 3
    cyc(1'b1, 2'b10, 16'h5555, 4'b0000);
    cyc(1'b1, 2'b00, 16'h1111, 4'b0000);
    cyc(1'b1, 2'b11, 16'h2222, 4'b0000);
    chk("iso_valid", {28'h0, bus.out_valid}, 32'hD);
    cyc(1'b1, 2'b10, 16'h7777, 4'b0000);
    chk("iso_stall_sel2", {31'h0, bus.in_ready}, 32'h0);
    chk("iso_q2_held", {16'h0, bus.q2}, 32'h5555);
    cyc(1'b0, 2'b00, 16'h0, 4'b1001);
    chk("iso_q2_unchanged", {16'h0, bus.q2}, 32'h5555);
    cyc(1'b1, 2'b10, 16'h7777, 4'b0100);
    chk("iso_q2_reload", {16'h0, bus.q2}, 32'h7777);

    // Asynchronous reset mid-cycle with slot 2 full
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.out_ready = 4'b0000;
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    chk("arst_out_valid", {28'h0, bus.out_valid}, 32'h0);
    chk("arst_q2", {16'h0, bus.q2}, 32'h0);
    chk("arst_dcount2", {24'h0, bus.dcount2}, 32'h0);
    check_outputs("arst");
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("arst_in_ready", {31'h0, bus.in_ready}, 32'h1);

    // Counter wrap on slot 1
    for (int k = 0; k < 256; k++) begin
      cyc(1'b1, 2'b01, 16'(k), 4'b0010);
    end
    chk("wrap_dcount1_ff", {24'h0, bus.dcount1}, 32'hFF);
    cyc(1'b0, 2'b00, 16'h0, 4'b0010);
    chk("wrap_dcount1_00", {24'h0, bus.dcount1}, 32'h0);
    chk("wrap_dcount0", {24'h0, bus.dcount0}, 32'h0);
    chk("wrap_dcount2", {24'h0, bus.dcount2}, 32'h0);
    chk("wrap_dcount3", {24'h0, bus.dcount3}, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
